// File: rtl/nice_icb_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : nice_icb_mem_resp
// Description : ICB memory target for the NICE coprocessor memory port.
//               Accepts single-beat read/write commands, services them from
//               an internal word-addressed SRAM, and returns in-order
//               responses after a fixed latency with bounded outstanding
//               transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module nice_icb_mem_resp #(
    parameter int                ADDR_W     = 32,
    parameter int                DW         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h2000_0000,
    parameter int                DEPTH      = 4096,
    parameter int                LATENCY    = 2,
    parameter int                OUTS_DEPTH = 4
) (
    input  logic              nice_clk,
    input  logic              nice_rst_n,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [ADDR_W-1:0] icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [DW-1:0]     icb_cmd_wdata,
    input  logic [DW/8-1:0]   icb_cmd_wmask,
    input  logic [1:0]        icb_cmd_size,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic [DW-1:0]     icb_rsp_rdata,
    output logic              icb_rsp_err
);

    localparam int c_MW    = DW / 8;
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_FP_W  = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(OUTS_DEPTH + 1);

    // One extra bit so a memory spanning the whole address space still compares correctly
    localparam logic [ADDR_W:0]    c_MEM_BYTES = (ADDR_W + 1)'(DEPTH) << 2;
    localparam logic [c_CNT_W-1:0] c_OUTS_MAX  = c_CNT_W'(OUTS_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_FP_W-1:0]  c_PTR_LAST  = c_FP_W'(OUTS_DEPTH - 1);
    localparam logic [c_FP_W-1:0]  c_PTR_ONE   = c_FP_W'(1);

    // Storage
    logic [DW-1:0]         r_mem       [DEPTH];
    logic [DW-1:0]         r_fifo_data [OUTS_DEPTH];
    logic [OUTS_DEPTH-1:0] r_fifo_err;
    logic [c_FP_W-1:0]     r_wr_ptr;
    logic [c_FP_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]    r_fifo_cnt;
    logic [c_CNT_W-1:0]    r_inflight;

    // Command decode
    logic              w_accept;
    logic [ADDR_W-1:0] w_offset;
    logic              w_oor;
    logic              w_misalign;
    logic              w_bad_size;
    logic              w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic              w_wr_en;
    logic [DW-1:0]     w_rd_word;

    // Pipe output into the response FIFO
    logic              w_push;
    logic              w_push_err;
    logic [DW-1:0]     w_push_data;
    logic              w_pop;

    assign w_accept   = icb_cmd_valid && icb_cmd_ready;
    // Unsigned wrap makes below-base addresses land far out of range
    assign w_offset   = icb_cmd_addr - BASE_ADDR;
    assign w_oor      = {1'b0, w_offset} >= c_MEM_BYTES;
    assign w_misalign = ((icb_cmd_size == 2'd1) && icb_cmd_addr[0]) ||
                        ((icb_cmd_size == 2'd2) && (icb_cmd_addr[1:0] != 2'b00));
    assign w_bad_size = (icb_cmd_size == 2'd3);
    assign w_err      = w_oor || w_misalign || w_bad_size;
    assign w_idx      = w_offset[c_IDX_W+1:2];
    assign w_wr_en    = w_accept && !icb_cmd_read && !w_err;
    // Read data is captured with the command; writes and errors carry zero
    assign w_rd_word  = (icb_cmd_read && !w_err) ? r_mem[w_idx] : '0;

    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle
    assign icb_cmd_ready = (r_inflight < c_OUTS_MAX);
    assign icb_rsp_valid = (r_fifo_cnt != '0);
    assign w_pop         = icb_rsp_valid && icb_rsp_ready;
    // Gate the head with valid so idle outputs read as zero
    assign icb_rsp_rdata = icb_rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign icb_rsp_err   = icb_rsp_valid ? r_fifo_err[r_rd_ptr]  : 1'b0;

    // Byte-lane update of accepted, non-erroring writes; contents survive reset
    always_ff @(posedge nice_clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < c_MW; b++) begin
                if (icb_cmd_wmask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= icb_cmd_wdata[8*b +: 8];
                end
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign w_push      = w_accept;
            assign w_push_err  = w_err;
            assign w_push_data = w_rd_word;
        end else begin : g_pipe
            localparam int c_STAGES = LATENCY - 1;
            logic [c_STAGES-1:0] r_pv;
            logic [c_STAGES-1:0] r_pe;
            logic [DW-1:0]       r_pd [c_STAGES];

            // Free-running delay line; the inflight bound guarantees FIFO room at its end
            always_ff @(posedge nice_clk or negedge nice_rst_n) begin
                if (!nice_rst_n) begin
                    r_pv <= '0;
                    r_pe <= '0;
                    for (int s = 0; s < c_STAGES; s++) begin
                        r_pd[s] <= '0;
                    end
                end else begin
                    r_pv[0] <= w_accept;
                    r_pe[0] <= w_err;
                    r_pd[0] <= w_rd_word;
                    for (int s = 1; s < c_STAGES; s++) begin
                        r_pv[s] <= r_pv[s-1];
                        r_pe[s] <= r_pe[s-1];
                        r_pd[s] <= r_pd[s-1];
                    end
                end
            end

            assign w_push      = r_pv[c_STAGES-1];
            assign w_push_err  = r_pe[c_STAGES-1];
            assign w_push_data = r_pd[c_STAGES-1];
        end
    endgenerate

    // Response FIFO payload; only pointers and counts need reset
    always_ff @(posedge nice_clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_push_data;
            r_fifo_err[r_wr_ptr]  <= w_push_err;
        end
    end

    // FIFO pointers, FIFO occupancy and total in-flight count
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_inflight <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CNT_ONE;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CNT_ONE;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            case ({w_accept, w_pop})
                2'b10:   r_inflight <= r_inflight + c_CNT_ONE;
                2'b01:   r_inflight <= r_inflight - c_CNT_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule
`default_nettype wire
